srl_stim_seq: RTL and testbench

// - Stimulus sequencer and self-checker for a slice of SRLC32E shift registers sharing CLK/CE/D/A.
// - Drives CE, D (LFSR bits) and A, mirrors SRL contents in a shadow register, compares every lane's Q.
// - Sits directly upstream of the SRL slice and also consumes its Q bus; reports a sticky per-lane error.

---
 rtl/srl_test_pkg.sv | 20 ++
 rtl/srl_lfsr32.sv | 26 ++
 rtl/srl_stim_seq.sv | 155 +++++++++++++++
 tb/tb_srl_stim_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_test_pkg.sv
// Shared types and constants for the SRL stimulus sequencer.
// Holds the sequencer state encoding and the LFSR polynomial.
package srl_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SWEEP,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK         = 32'h80200003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE11234;

  // Galois right-shift step: the mask is folded in when the outgoing bit is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/srl_lfsr32.sv
// 32-bit Galois LFSR; lsb is the bit to be consumed, step advances by one.
// Only reset reseeds it, so successive rounds and runs see fresh bits.
module srl_lfsr32
  import srl_test_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic lsb
);

  logic [31:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

  assign lsb = state[0];

endmodule

// File: rtl/srl_stim_seq.sv
// Stimulus sequencer and checker for a slice of SRLC32E shift registers sharing CE/D/A.
// Fills the SRLs from an LFSR, mirrors them in a shadow register and sweeps A comparing every lane.
//
// Handshake: START is a level. In IDLE, START=1 starts a run at the next edge; BUSY stays
// high for the whole FILL/SWEEP run; DONE stays high until START is seen low, then IDLE.
module srl_stim_seq
  import srl_test_pkg::*;
#(
  parameter int          DEPTH     = 32,
  parameter int          ADDR_W    = 5,
  parameter int          LANES     = 4,
  parameter int          HOLD      = 2,
  parameter int          ROUNDS    = 4,
  parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [LANES-1:0]  Q_IN,
  output logic              CE,
  output logic              D,
  output logic [ADDR_W-1:0] A,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [LANES-1:0]  ERR_LANES,
  output logic [7:0]        ROUND,
  output state_t            dbg_state
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_t            state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [HW-1:0]     hold_cnt;
  logic [DEPTH-1:0]  shadow;
  logic              lfsr_bit;
  logic              load_bit;
  logic              last_fill;
  logic              last_hold;
  logic              last_addr;
  logic              more_rounds;
  logic [LANES-1:0]  mismatch;

  assign last_fill   = (fill_cnt == ADDR_W'(DEPTH - 1));
  assign last_hold   = (hold_cnt == HW'(HOLD - 1));
  assign last_addr   = (A == ADDR_W'(DEPTH - 1));
  assign more_rounds = (ROUND < 8'(ROUNDS - 1));
  assign mismatch    = Q_IN ^ {LANES{shadow[A]}};
  assign dbg_state   = state;

  // The LFSR advances exactly when a new bit is registered onto D.
  always_comb begin
    load_bit = 1'b0;
    case (state)
      ST_IDLE:  load_bit = START;
      ST_FILL:  load_bit = !last_fill;
      ST_SWEEP: load_bit = last_hold && last_addr && more_rounds;
      default:  load_bit = 1'b0;
    endcase
  end

  srl_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (CLK),
    .rst  (RST),
    .step (load_bit),
    .lsb  (lfsr_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      CE        <= 1'b0;
      D         <= 1'b0;
      A         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      ERR_LANES <= '0;
      ROUND     <= '0;
      shadow    <= '0;
      fill_cnt  <= '0;
      hold_cnt  <= '0;
    end else begin
      // Same edge and same CE/D the SRLs see, so shadow tracks their contents.
      if (CE) begin
        shadow <= {shadow[DEPTH-2:0], D};
      end
      case (state)
        ST_IDLE: begin
          CE <= 1'b0;
          if (START) begin
            state     <= ST_FILL;
            BUSY      <= 1'b1;
            CE        <= 1'b1;
            D         <= lfsr_bit;
            fill_cnt  <= '0;
            ERR       <= 1'b0;
            ERR_LANES <= '0;
            ROUND     <= '0;
          end
        end
        ST_FILL: begin
          if (last_fill) begin
            state    <= ST_SWEEP;
            CE       <= 1'b0;
            A        <= '0;
            hold_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
            D        <= lfsr_bit;
          end
        end
        ST_SWEEP: begin
          if (last_hold) begin
            // Q_IN has settled for this address by the last hold cycle.
            if (|mismatch) begin
              ERR <= 1'b1;
            end
            ERR_LANES <= ERR_LANES | mismatch;
            hold_cnt  <= '0;
            if (last_addr) begin
              A <= '0;
              if (more_rounds) begin
                state    <= ST_FILL;
                ROUND    <= ROUND + 8'd1;
                CE       <= 1'b1;
                D        <= lfsr_bit;
                fill_cnt <= '0;
              end else begin
                state <= ST_DONE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
              end
            end else begin
              A <= A + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!START) begin
            state <= ST_IDLE;
            DONE  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srl_stim_seq.sv
// Bench for srl_stim_seq: SRL slice model on Q_IN, LFSR reference for D, scoreboard on run results.
module tb_srl_stim_seq;
  import srl_test_pkg::*;

  localparam int          DEPTH  = 32;
  localparam int          ADDR_W = 5;
  localparam int          LANES  = 4;
  localparam int          HOLD   = 2;
  localparam int          ROUNDS = 4;
  localparam logic [31:0] SEED   = 32'hACE11234;
  localparam logic [31:0] POLY   = 32'h80200003;
  localparam int          RUN_BUSY = ROUNDS * (DEPTH + DEPTH * HOLD);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT (HOLD=2)
  logic              start;
  logic [LANES-1:0]  q_in;
  logic              ce, d, busy, done, err;
  logic [ADDR_W-1:0] a;
  logic [LANES-1:0]  err_lanes;
  logic [7:0]        round;
  state_t            st;

  srl_stim_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LANES(LANES), .HOLD(HOLD),
                 .ROUNDS(ROUNDS), .LFSR_SEED(SEED)) dut (
    .CLK(clk), .RST(rst), .START(start), .Q_IN(q_in), .CE(ce), .D(d), .A(a),
    .BUSY(busy), .DONE(done), .ERR(err), .ERR_LANES(err_lanes), .ROUND(round),
    .dbg_state(st));

  // second DUT with HOLD=1, always fed by a registered (one-cycle late) SRL
  logic              start_h1;
  logic [LANES-1:0]  q_h1;
  logic              ce_h1, d_h1, busy_h1, done_h1, err_h1;
  logic [ADDR_W-1:0] a_h1;
  logic [LANES-1:0]  err_lanes_h1;
  logic [7:0]        round_h1;
  state_t            st_h1;

  srl_stim_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LANES(LANES), .HOLD(1),
                 .ROUNDS(ROUNDS), .LFSR_SEED(SEED)) dut_h1 (
    .CLK(clk), .RST(rst), .START(start_h1), .Q_IN(q_h1), .CE(ce_h1), .D(d_h1), .A(a_h1),
    .BUSY(busy_h1), .DONE(done_h1), .ERR(err_h1), .ERR_LANES(err_lanes_h1), .ROUND(round_h1),
    .dbg_state(st_h1));

  // SRL slice models: all lanes share CE/D/A so they hold identical data
  int          mode;  // 0 ideal, 1 lane 2 stuck-at-0, 2 registered Q
  logic [31:0] srl_m = '0;
  logic [31:0] srl_h = '0;
  logic [LANES-1:0] q_dly_m = '0;
  logic [LANES-1:0] q_dly_h = '0;
  logic [LANES-1:0] q_ideal_m;

  always @(posedge clk) begin
    if (ce)    srl_m <= {srl_m[30:0], d};
    if (ce_h1) srl_h <= {srl_h[30:0], d_h1};
    q_dly_m <= {LANES{srl_m[a]}};
    q_dly_h <= {LANES{srl_h[a_h1]}};
  end

  always_comb begin
    q_ideal_m = {LANES{srl_m[a]}};
    q_in      = q_ideal_m;
    if (mode == 1) q_in = q_ideal_m & 4'b1011;
    else if (mode == 2) q_in = q_dly_m;
    q_h1 = q_dly_h;
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [0:0] exp_d_q[$];
  logic [4:0] exp_res_q[$];  // {err, err_lanes}
  logic [31:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing at %0t", name, $time);
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] n;
    n = s / 2;
    if (s % 2 == 1) n = n ^ POLY;
    return n;
  endfunction

  // Reference for one full run: D bit stream and final error state.
  task automatic push_run_expect(input int md);
    logic [31:0] bits;
    logic        e;
    logic [3:0]  l;
    e = 1'b0;
    l = 4'b0;
    for (int r = 0; r < ROUNDS; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        bits[i] = m_lfsr[0];
        exp_d_q.push_back(m_lfsr[0]);
        m_lfsr = ref_next(m_lfsr);
      end
      // a stuck-at-0 lane disagrees wherever the SRL holds a 1
      if (md == 1 && bits != 32'h0) begin
        e = 1'b1;
        l = 4'b0100;
      end
    end
    exp_res_q.push_back({e, l});
  endtask

  // monitor
  logic prev_busy = 1'b0;
  logic done_seen = 1'b0;
  int   busy_cnt = 0;
  int   ce_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      done_seen = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        busy_cnt = 0;
        ce_cnt   = 0;
      end
      if (busy) busy_cnt++;
      if (ce) begin
        ce_cnt++;
        check("ce_only_when_busy", busy, 1);
        check("a_zero_in_fill", a, 0);
        if (exp_d_q.size() == 0) check_fail("d_unexpected");
        else check("d_bit", d, exp_d_q.pop_front());
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        if (exp_res_q.size() == 0) check_fail("done_unexpected");
        else begin
          logic [4:0] r;
          r = exp_res_q.pop_front();
          check("run_err", err, r[4]);
          check("run_err_lanes", err_lanes, r[3:0]);
          check("run_busy_cycles", busy_cnt, RUN_BUSY);
          check("run_ce_cycles", ce_cnt, ROUNDS * DEPTH);
        end
      end
      if (!done) done_seen = 1'b0;
      prev_busy = busy;
    end
  end

  // driver tasks
  task automatic run_main(input int md, input bit drop_early);
    int n;
    mode = md;
    push_run_expect(md);
    start = 1'b1;
    if (drop_early) begin
      repeat ($urandom_range(2, DEPTH - 2)) @(negedge clk);
      check("busy_before_drop", busy, 1);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_fail("main_done_timeout");
    if (drop_early) begin
      @(negedge clk);
      check("done_pulse_one_cycle", done, 0);
      check("idle_after_pulse", st, ST_IDLE);
    end else begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      check("done_held", done, 1);
      start = 1'b0;
      @(negedge clk);
      check("done_released", done, 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_h1();
    logic [31:0] h;
    logic [31:0] bits;
    logic        e;
    int          n;
    h = SEED;
    e = 1'b0;
    // a one-cycle-late Q mismatches unless every round's data is constant
    for (int r = 0; r < ROUNDS; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        bits[i] = h[0];
        h = ref_next(h);
      end
      if (bits != 32'h0 && bits != 32'hFFFF_FFFF) e = 1'b1;
    end
    start_h1 = 1'b1;
    n = 0;
    while (!done_h1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done_h1) check_fail("h1_done_timeout");
    check("h1_err", err_h1, e);
    check("h1_err_lanes", err_lanes_h1, {LANES{e}});
    start_h1 = 1'b0;
    @(negedge clk);
    check("h1_done_released", done_h1, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    start_h1 = 1'b0;
    mode = 0;
    m_lfsr = SEED;
    repeat (3) @(negedge clk);
    check("rst_ce", ce, 0);
    check("rst_d", d, 0);
    check("rst_a", a, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_lanes", err_lanes, 0);
    check("rst_round", round, 0);
    check("rst_state", st, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    run_main(0, 1'b0);
    run_main(1, 1'b0);
    run_main(2, 1'b0);
    run_main(0, 1'b1);

    // reset in the middle of round 1's sweep
    mode = 0;
    push_run_expect(0);
    start = 1'b1;
    n = 0;
    while (!(st == ST_SWEEP && round == 8'd1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(st == ST_SWEEP && round == 8'd1)) check_fail("round1_sweep_timeout");
    repeat ($urandom_range(1, 20)) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrst_ce", ce, 0);
    check("midrst_a", a, 0);
    check("midrst_busy", busy, 0);
    check("midrst_round", round, 0);
    check("midrst_state", st, ST_IDLE);
    exp_d_q.delete();
    exp_res_q.delete();
    m_lfsr = SEED;
    rst = 1'b0;
    @(negedge clk);
    run_main(0, 1'b0);

    run_h1();

    check("exp_d_q_drained", exp_d_q.size(), 0);
    check("exp_res_q_drained", exp_res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
